// File: rtl/tt_spine_sel.sv
// tt_spine_sel: spine select/enable controller with break-before-make.
// Optional DROP/BLANK sequencing enabled by TT_SPINE_SEL_BLANK_EN.
module tt_spine_sel #(
    parameter int SEL_W       = 9,
    parameter int SYNC_STAGES = 2,
    parameter int BLANK_CYC   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ctrl_sel_rst_n,
    input  logic             ctrl_sel_inc,
    input  logic             ctrl_ena,
    output logic [SEL_W-1:0] spine_sel,
    output logic             spine_ena,
    output logic [SEL_W-1:0] sel_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DROP,
        BLANK
    } state_t;

    localparam logic [SEL_W-1:0] ONE = SEL_W'(1);

    logic [SYNC_STAGES-1:0] r_rst_sync;
    logic [SYNC_STAGES-1:0] r_inc_sync;
    logic [SYNC_STAGES-1:0] r_ena_sync;
    logic                   r_inc_q;
    logic [SEL_W-1:0]       r_cnt;
    logic [SEL_W-1:0]       r_sel;
    logic                   r_ena;
    state_t                 r_state;
    state_t                 w_nxt;
    logic                   w_rst_s;
    logic                   w_inc_s;
    logic                   w_ena_s;
    logic                   w_inc_edge;

    assign w_rst_s    = r_rst_sync[SYNC_STAGES-1];
    assign w_inc_s    = r_inc_sync[SYNC_STAGES-1];
    assign w_ena_s    = r_ena_sync[SYNC_STAGES-1];
    assign w_inc_edge = w_inc_s & ~r_inc_q;

    assign spine_sel = r_sel;
    assign spine_ena = r_ena;
    assign sel_cnt   = r_cnt;

    // Synchronize the three slow pins and delay inc for edge detect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rst_sync <= '0;
            r_inc_sync <= '0;
            r_ena_sync <= '0;
            r_inc_q    <= 1'b0;
        end else begin
            r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], ctrl_sel_rst_n};
            r_inc_sync <= {r_inc_sync[SYNC_STAGES-2:0], ctrl_sel_inc};
            r_ena_sync <= {r_ena_sync[SYNC_STAGES-2:0], ctrl_ena};
            r_inc_q    <= w_inc_s;
        end
    end

    // Address counter: select reset wins over increment, wraps naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!w_rst_s) begin
            r_cnt <= '0;
        end else if (w_inc_edge) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    // FSM state plus registered enable derived from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ena   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_ena   <= (w_nxt == ACTIVE);
        end
    end

`ifdef TT_SPINE_SEL_BLANK_EN
    localparam int BW = (BLANK_CYC < 2) ? 1 : $clog2(BLANK_CYC + 1);

    logic [BW-1:0] r_blank;
    logic          r_busy;

    assign busy = r_busy;

    // Next state: any address change goes through DROP then BLANK
    always_comb begin
        w_nxt = r_state;
        if (!w_rst_s) begin
            w_nxt = (r_sel != '0) ? DROP : IDLE;
        end else if (w_inc_edge) begin
            w_nxt = DROP;
        end else begin
            unique case (r_state)
                IDLE, ACTIVE: w_nxt = w_ena_s ? ACTIVE : IDLE;
                DROP:         w_nxt = BLANK;
                BLANK: begin
                    if (r_blank == BW'(1)) begin
                        w_nxt = w_ena_s ? ACTIVE : IDLE;
                    end
                end
                default:      w_nxt = IDLE;
            endcase
        end
    end

    // Spine address loads only in DROP, after enable is already low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel   <= '0;
            r_blank <= '0;
            r_busy  <= 1'b0;
        end else begin
            if (r_state == DROP) begin
                r_sel   <= r_cnt;
                r_blank <= BW'(BLANK_CYC);
            end else if (r_state == BLANK && r_blank != '0) begin
                r_blank <= r_blank - BW'(1);
            end
            r_busy <= (w_nxt == DROP) || (w_nxt == BLANK);
        end
    end
`else
    assign busy = 1'b0;

    // Next state: enable simply follows the synchronized request
    always_comb begin
        w_nxt = IDLE;
        unique case (r_state)
            IDLE, ACTIVE: w_nxt = (w_ena_s && w_rst_s) ? ACTIVE : IDLE;
            default:      w_nxt = IDLE;
        endcase
    end

    // Spine address tracks the counter's next value directly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel <= '0;
        end else if (!w_rst_s) begin
            r_sel <= '0;
        end else if (w_inc_edge) begin
            r_sel <= r_cnt + ONE;
        end
    end
`endif

endmodule

// File: tb/tb_tt_spine_sel.sv
// tb_tt_spine_sel: directed bench for tt_spine_sel.
// Expectations follow TT_SPINE_SEL_BLANK_EN when defined.
module tb_tt_spine_sel;

`ifdef TT_SPINE_SEL_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif
    localparam int BCYC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ctrl_sel_rst_n = 1'b1;
    logic       ctrl_sel_inc = 1'b0;
    logic       ctrl_ena = 1'b0;
    logic [8:0] spine_sel;
    logic       spine_ena;
    logic [8:0] sel_cnt;
    logic       busy;

    int checks = 0;
    int failures = 0;

    bit mon_en = 1'b0;
    logic [8:0] prev_sel = '0;
    logic prev_ena = 1'b0;
    int rises = 0;
    int run_low = 0;
    int min_low = 1000;
    int low_cnt = 0;
    int busy_hi = 0;
    int viol = 0;

    tt_spine_sel #(
        .SEL_W(9),
        .SYNC_STAGES(2),
        .BLANK_CYC(BCYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ctrl_sel_rst_n(ctrl_sel_rst_n),
        .ctrl_sel_inc(ctrl_sel_inc),
        .ctrl_ena(ctrl_ena),
        .spine_sel(spine_sel),
        .spine_ena(spine_ena),
        .sel_cnt(sel_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Observe outputs mid-cycle: enable runs, rises, address stability
    always @(negedge clk) begin
        if (rst_n) begin
            if (spine_ena && !prev_ena) rises <= rises + 1;
            if (busy) busy_hi <= busy_hi + 1;
            if (BLANK && spine_sel != prev_sel && (spine_ena || prev_ena))
                viol <= viol + 1;
            if (mon_en) begin
                if (!spine_ena) begin
                    run_low <= run_low + 1;
                    low_cnt <= low_cnt + 1;
                end else begin
                    if (!prev_ena && run_low < min_low) min_low <= run_low;
                    run_low <= 0;
                end
            end
        end
        prev_sel <= spine_sel;
        prev_ena <= spine_ena;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        ctrl_sel_inc = 1'b1;
        cyc(hi);
        ctrl_sel_inc = 1'b0;
        cyc(lo);
    endtask

    int r0;
    int b0;

    initial begin
        cyc(2);
        @(negedge clk);
        check("rst_sel", spine_sel, 0);
        check("rst_ena", spine_ena, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", sel_cnt, 0);
        rst_n = 1'b1;
        cyc(4);

        ctrl_ena = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("ena_lat_early", spine_ena, 0);
        @(posedge clk);
        @(negedge clk);
        check("ena_lat", spine_ena, 1);
        cyc(3);

        r0 = rises;
        b0 = busy_hi;
        mon_en = 1'b1;
        for (int i = 0; i < 37; i++) pulse(4, 4);
        cyc(12);
        mon_en = 1'b0;
        @(negedge clk);
        check("inc37_sel", spine_sel, 37);
        check("inc37_cnt", sel_cnt, 37);
        check("inc37_ena", spine_ena, 1);
        check("inc37_busy", busy, 0);
        check("inc37_rises", rises - r0, BLANK ? 37 : 0);
        check("inc37_busy_seen", busy_hi > b0, BLANK);
        check("blank_len",
              BLANK ? (min_low >= BCYC + 1) : (low_cnt == 0), 1);

        for (int i = 0; i < 474; i++) pulse(4, 4);
        cyc(12);
        @(negedge clk);
        check("max_sel", spine_sel, 511);
        check("max_cnt", sel_cnt, 511);
        pulse(4, 4);
        cyc(12);
        @(negedge clk);
        check("wrap_sel", spine_sel, 0);
        check("wrap_cnt", sel_cnt, 0);

        pulse(4, 4);
        cyc(12);
        @(negedge clk);
        check("pre_rst_sel", spine_sel, 1);
        #1;
        ctrl_sel_inc = 1'b1;
        ctrl_sel_rst_n = 1'b0;
        cyc(4);
        ctrl_sel_inc = 1'b0;
        cyc(6);
        @(negedge clk);
        check("srst_cnt", sel_cnt, 0);
        check("srst_sel", spine_sel, 0);
        check("srst_ena", spine_ena, 0);
        check("srst_busy", busy, 0);
        #1;
        ctrl_sel_rst_n = 1'b1;
        cyc(6);
        @(negedge clk);
        check("srst_rel_ena", spine_ena, 1);
        #1;

        r0 = rises;
        pulse(2, 2);
        pulse(2, 20);
        @(negedge clk);
        check("dbl_sel", spine_sel, 2);
        check("dbl_cnt", sel_cnt, 2);
        check("dbl_rises", rises - r0, BLANK ? 1 : 0);
        check("dbl_ena", spine_ena, 1);
        check("dbl_busy", busy, 0);

        check("sel_stable", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
